// File: rtl/md_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : md_ctrl_pkg
// Brief  : Mult/div op encodings and op-decoding helpers.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
package md_ctrl_pkg;

    localparam int MD_OP_BUS = 2;

    localparam logic [MD_OP_BUS-1:0] MD_OP_MULT  = 2'b00;
    localparam logic [MD_OP_BUS-1:0] MD_OP_MULTU = 2'b01;
    localparam logic [MD_OP_BUS-1:0] MD_OP_DIV   = 2'b10;
    localparam logic [MD_OP_BUS-1:0] MD_OP_DIVU  = 2'b11;

    // Bit 0 clear marks the signed variants, bit 1 set marks the divides.
    function automatic logic md_is_signed(input logic [MD_OP_BUS-1:0] op);
        return ~op[0];
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_BUS-1:0] op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : md_step
// Brief  : One radix-2 iteration: shift-add multiply or restoring divide.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module md_step
#(
    parameter int WIDTH = 32
)(
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    input  logic               i_is_div,
    output logic [2*WIDTH-1:0] o_acc_nxt
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
        w_rem_sh  = i_acc[2*WIDTH-1:WIDTH-1];
        // Remainder after a successful trial subtract always fits in WIDTH bits.
        w_diff    = w_rem_sh[WIDTH-1:0] - i_operand;
        o_acc_nxt = '0;
        if (i_is_div) begin
            if (w_rem_sh >= {1'b0, i_operand})
                o_acc_nxt = {w_diff, i_acc[WIDTH-2:0], 1'b1};
            else
                o_acc_nxt = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
        end else if (i_acc[0]) begin
            o_acc_nxt = {w_sum, i_acc[WIDTH-1:1]};
        end else begin
            o_acc_nxt = {1'b0, i_acc[2*WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : md_ctrl
// Brief  : Iterative MULT/MULTU/DIV/DIVU sequencer with pipeline stall.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MD_OP_BUS-1:0] op,
    input  logic [WIDTH-1:0]     operand_1,
    input  logic [WIDTH-1:0]     operand_2,
    input  logic                 flush,
    output logic                 stall_req,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    localparam int               CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_busy;
    logic [MD_OP_BUS-1:0] r_op;
    logic                 r_sign_1;
    logic                 r_sign_2;
    logic [WIDTH-1:0]     r_operand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_accept;
    logic                 w_signed;
    logic                 w_is_div;
    logic                 w_div0;
    logic [WIDTH-1:0]     w_mag_1;
    logic [WIDTH-1:0]     w_mag_2;
    logic [2*WIDTH-1:0]   w_step;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    assign w_accept = (r_state == S_IDLE) & start & ~flush;
    assign w_signed = md_is_signed(op);
    assign w_is_div = md_is_div(op);
    assign w_div0   = w_is_div & (operand_2 == '0);
    assign w_mag_1  = (w_signed & operand_1[WIDTH-1]) ? -operand_1 : operand_1;
    assign w_mag_2  = (w_signed & operand_2[WIDTH-1]) ? -operand_2 : operand_2;

    md_step #(.WIDTH(WIDTH)) u_step (
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .i_is_div  (md_is_div(r_op)),
        .o_acc_nxt (w_step)
    );

    // Sign flags are latched as zero for unsigned ops, so FIX needs no op check there.
    always_comb begin
        w_prod   = (r_sign_1 ^ r_sign_2) ? -r_acc : r_acc;
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (md_is_div(r_op)) begin
            w_fix_lo = (r_sign_1 ^ r_sign_2) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_fix_hi = r_sign_1 ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_nxt = w_div0 ? S_DONE : S_ITER;
                S_ITER:  if (r_cnt == C_LAST) w_state_nxt = S_FIX;
                S_FIX:   w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_req = ~rst & (w_accept | (r_state == S_ITER) | (r_state == S_FIX));
        done      = (r_state == S_DONE);
        busy      = r_busy;
        hi        = r_hi;
        lo        = r_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= MD_OP_MULT;
            r_sign_1  <= 1'b0;
            r_sign_2  <= 1'b0;
            r_operand <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= op;
                r_sign_1  <= w_signed & operand_1[WIDTH-1];
                r_sign_2  <= w_signed & operand_2[WIDTH-1];
                r_cnt     <= '0;
                // Multiply: multiplier in the low half; divide: dividend in the low half.
                r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_1 : w_mag_2)};
                r_operand <= w_is_div ? w_mag_2 : w_mag_1;
                if (w_div0) begin
                    r_hi <= operand_1;
                    r_lo <= '1;
                end
            end
            if (r_state == S_ITER) begin
                r_acc <= w_step;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == S_FIX) && !flush) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_md_ctrl
// Brief  : Directed self-checking bench for md_ctrl.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_md_ctrl;
    import md_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    md_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one instruction from the accept cycle (cycle 0) until done; returns one cycle after done, start still high.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int dcyc, output int scnt, output logic s_done, output logic b_done);
        start = 1'b1; op = o; operand_1 = a; operand_2 = b;
        dcyc = -1; scnt = 0; s_done = 1'b1; b_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (stall_req) scnt++;
            if (done) begin
                dcyc = c; s_done = stall_req; b_done = busy;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; op = MD_OP_MULTU; operand_1 = 32'd9; operand_2 = 32'd9; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_multu;
        int d, s; logic sd, bd;
        issue(MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, d, s, sd, bd);
        start = 1'b0;
        n_tests++; if (d != 34) begin n_fail++; $display("FAIL multu_latency: got %0d want 34", d); end
        n_tests++; if (s != 34) begin n_fail++; $display("FAIL multu_stall_cycles: got %0d want 34", s); end
        n_tests++; if (sd !== 1'b0) begin n_fail++; $display("FAIL multu_stall_in_done: got %b want 0", sd); end
        n_tests++; if (bd !== 1'b1) begin n_fail++; $display("FAIL multu_busy_in_done: got %b want 1", bd); end
        n_tests++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_tests++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_after: got %b want 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_mult;
        int d, s; logic sd, bd;
        issue(MD_OP_MULT, 32'hFFFFFFFD, 32'd7, d, s, sd, bd);
        start = 1'b0;
        n_tests++; if (d != 34) begin n_fail++; $display("FAIL mult_latency: got %0d want 34", d); end
        n_tests++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_tests++; if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    endtask

    task automatic test_div;
        int d, s; logic sd, bd;
        issue(MD_OP_DIV, 32'hFFFFFFF9, 32'd2, d, s, sd, bd);
        start = 1'b0;
        n_tests++; if (d != 34) begin n_fail++; $display("FAIL div_latency: got %0d want 34", d); end
        n_tests++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg7_2_lo: got %h want fffffffd", lo); end
        n_tests++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg7_2_hi: got %h want ffffffff", hi); end
        issue(MD_OP_DIV, 32'd7, 32'hFFFFFFFE, d, s, sd, bd);
        start = 1'b0;
        n_tests++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_7_neg2_lo: got %h want fffffffd", lo); end
        n_tests++; if (hi !== 32'h00000001) begin n_fail++; $display("FAIL div_7_neg2_hi: got %h want 00000001", hi); end
        issue(MD_OP_DIVU, 32'd100, 32'd7, d, s, sd, bd);
        start = 1'b0;
        n_tests++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_100_7_lo: got %h want 0000000e", lo); end
        n_tests++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_100_7_hi: got %h want 00000002", hi); end
        issue(MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, d, s, sd, bd);
        start = 1'b0;
        n_tests++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL div_min_neg1_lo: got %h want 80000000", lo); end
        n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL div_min_neg1_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_div_zero;
        int d, s; logic sd, bd;
        issue(MD_OP_DIVU, 32'd5, 32'd0, d, s, sd, bd);
        start = 1'b0;
        n_tests++; if (d != 1) begin n_fail++; $display("FAIL divu0_latency: got %0d want 1", d); end
        n_tests++; if (s != 1) begin n_fail++; $display("FAIL divu0_stall_cycles: got %0d want 1", s); end
        n_tests++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0_lo: got %h want ffffffff", lo); end
        n_tests++; if (hi !== 32'd5) begin n_fail++; $display("FAIL divu0_hi: got %h want 00000005", hi); end
        issue(MD_OP_DIV, 32'hFFFFFFF9, 32'd0, d, s, sd, bd);
        start = 1'b0;
        n_tests++; if (d != 1) begin n_fail++; $display("FAIL div0_latency: got %0d want 1", d); end
        n_tests++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        n_tests++; if (hi !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL div0_hi: got %h want fffffff9", hi); end
    endtask

    task automatic test_flush;
        int d, s; logic sd, bd; logic seen;
        issue(MD_OP_DIVU, 32'd100, 32'd7, d, s, sd, bd);
        start = 1'b1; op = MD_OP_MULT; operand_1 = 32'd6; operand_2 = 32'd7;
        seen = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) flush = 1'b1;
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall_req); end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b want 0", seen); end
        n_tests++; if (hi !== 32'd2) begin n_fail++; $display("FAIL flush_hi_hold: got %h want 00000002", hi); end
        n_tests++; if (lo !== 32'd14) begin n_fail++; $display("FAIL flush_lo_hold: got %h want 0000000e", lo); end
        @(posedge clk); #1;
        issue(MD_OP_MULT, 32'd6, 32'hFFFFFFF9, d, s, sd, bd);
        start = 1'b0;
        n_tests++; if (12 + d != 46) begin n_fail++; $display("FAIL flush_restart_cycle: got %0d want 46", 12 + d); end
        n_tests++; if (lo !== 32'hFFFFFFD6) begin n_fail++; $display("FAIL flush_restart_lo: got %h want ffffffd6", lo); end
        n_tests++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL flush_restart_hi: got %h want ffffffff", hi); end
    endtask

    task automatic test_start_flush;
        start = 1'b1; flush = 1'b1; op = MD_OP_MULTU; operand_1 = 32'd3; operand_2 = 32'd3;
        @(negedge clk);
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL start_flush_stall: got %b want 0", stall_req); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_flush_busy: got %b want 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int d, s; logic sd, bd;
        issue(MD_OP_MULTU, 32'd3, 32'd5, d, s, sd, bd);
        // start stays high into the IDLE cycle after DONE: a fresh instruction.
        issue(MD_OP_DIVU, 32'd50, 32'd6, d, s, sd, bd);
        start = 1'b0;
        n_tests++; if (d != 34) begin n_fail++; $display("FAIL b2b_latency: got %0d want 34", d); end
        n_tests++; if (lo !== 32'd8) begin n_fail++; $display("FAIL b2b_lo: got %h want 00000008", lo); end
        n_tests++; if (hi !== 32'd2) begin n_fail++; $display("FAIL b2b_hi: got %h want 00000002", hi); end
    endtask

    task automatic test_start_held;
        int d, s, extra; logic sd, bd;
        issue(MD_OP_MULTU, 32'h00010000, 32'h00010003, d, s, sd, bd);
        start = 1'b0;
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) extra++;
            @(posedge clk); #1;
        end
        n_tests++; if (d != 34) begin n_fail++; $display("FAIL held_latency: got %0d want 34", d); end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL held_extra_done: got %0d want 0", extra); end
        n_tests++; if (hi !== 32'd1) begin n_fail++; $display("FAIL held_hi: got %h want 00000001", hi); end
        n_tests++; if (lo !== 32'h00030000) begin n_fail++; $display("FAIL held_lo: got %h want 00030000", lo); end
    endtask

    task automatic test_rst_mid;
        start = 1'b1; op = MD_OP_MULTU; operand_1 = 32'hFFFFFFFF; operand_2 = 32'hFFFFFFFF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall_forced: got %b want 0", stall_req); end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", done); end
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b want 0", stall_req); end
        n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hi: got %h want 0", hi); end
        n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rst_mid_lo: got %h want 0", lo); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = MD_OP_MULT;
        operand_1 = '0; operand_2 = '0;
        #1;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_flush();
        test_start_flush();
        test_back_to_back();
        test_start_held();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
